biquad_coeff_loader: RTL

Wishbone initiator that bursts a block of biquad coefficient words into the coefficient registers of the `biquad8_wrapper` pair. It accepts a load command (base address plus word count), pulls coefficient words from a valid/ready stream, and issues single write cycles to consecutive word addresses. It handles retry, error and timeout, then reports completion. It sits upstream of the two-biquad design and drives that design's target-side `wb_` port.

---
 rtl/biquad_coeff_loader_pkg.sv | 22 ++
 rtl/biquad_coeff_loader_if.sv | 29 ++
 rtl/biquad_coeff_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/biquad_coeff_loader_pkg.sv
// Shared types for the biquad coefficient loader: FSM state encoding and error codes.
// The READ state exists only when BQLOAD_READBACK_EN is defined.
package bqload_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WRITE   = 3'd2,
      ST_BACKOFF = 3'd3,
`ifdef BQLOAD_READBACK_EN
      ST_READ    = 3'd4,
`endif
      ST_DONE    = 3'd5
   } bqload_state_t;

   localparam logic [2:0] BQLOAD_ERR_NONE     = 3'b000;
   localparam logic [2:0] BQLOAD_ERR_WB       = 3'b001;
   localparam logic [2:0] BQLOAD_ERR_RETRY    = 3'b010;
   localparam logic [2:0] BQLOAD_ERR_TIMEOUT  = 3'b011;
   localparam logic [2:0] BQLOAD_ERR_MISMATCH = 3'b100;

endpackage

// File: rtl/biquad_coeff_loader_if.sv
// Wishbone initiator/target bundle between the coefficient loader and the biquad pair.
// Signal names keep the initiator-side _o/_i suffixes of the loader's port list.
interface biquad_coeff_loader_if
   import bqload_pkg::*;
#(
   parameter int ADDR_WIDTH = 22,
   parameter int DATA_WIDTH = 32
);
   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic                  wb_we_o;
   logic [ADDR_WIDTH-1:0] wb_adr_o;
   logic [DATA_WIDTH-1:0] wb_dat_o;
   logic [3:0]            wb_sel_o;
   logic                  wb_ack_i;
   logic                  wb_err_i;
   logic                  wb_rty_i;
   logic [DATA_WIDTH-1:0] wb_dat_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
   );
endinterface

// File: rtl/biquad_coeff_loader.sv
// Wishbone initiator bursting stream-fed coefficient words to consecutive word addresses.
// Define BQLOAD_READBACK_EN to read each word back after its write ack and compare it.
module biquad_coeff_loader
   import bqload_pkg::*;
#(
   parameter int ADDR_WIDTH = 22,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255,
   parameter int MAX_RETRY  = 3
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_adr_i,
   input  logic [7:0]            count_i,
   input  logic [DATA_WIDTH-1:0] coeff_dat_i,
   input  logic                  coeff_valid_i,
   output logic                  coeff_ready_o,
   biquad_coeff_loader_if.master wb,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [2:0]            err_code_o,
   output logic [7:0]            words_done_o
);

   bqload_state_t         r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_base, r_adr, w_off;
   logic [DATA_WIDTH-1:0] r_dat;
   logic [7:0]            r_count, r_words, r_retry, r_tmo, w_cnt_eff;
   logic                  r_cyc, r_we, r_ready, r_busy, r_done, r_err;
   logic [3:0]            r_sel;
   logic [2:0]            r_err_code, w_err_nxt;
   logic                  w_active, w_hs, w_tmo, w_last, w_nxt_cyc;
   logic                  w_err_set, w_wr_ack, w_retry_inc;

`ifdef BQLOAD_READBACK_EN
   logic                  r_rb;
   assign w_active  = (r_state == ST_WRITE) || (r_state == ST_READ);
   assign w_nxt_cyc = (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_READ);
`else
   logic                  w_unused_rd;
   assign w_unused_rd = ^wb.wb_dat_i;
   assign w_active  = (r_state == ST_WRITE);
   assign w_nxt_cyc = (w_state_nxt == ST_WRITE);
`endif

   logic w_unused_base;
   assign w_unused_base = ^base_adr_i[1:0];

   assign w_hs      = (r_state == ST_FETCH) && r_ready && coeff_valid_i;
   assign w_tmo     = (r_tmo >= 8'(TIMEOUT - 1));
   assign w_last    = ((r_words + 8'd1) == r_count);
   assign w_off     = ADDR_WIDTH'({r_words, 2'b00});
   assign w_cnt_eff = (r_state == ST_IDLE) ? count_i : r_count;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_err_set   = 1'b0;
      w_err_nxt   = BQLOAD_ERR_NONE;
      w_wr_ack    = 1'b0;
      w_retry_inc = 1'b0;
      if (w_active) begin
         // termination priority err > rty > ack; timeout only when nothing terminated
         if (wb.wb_err_i) begin
            w_state_nxt = ST_DONE;
            w_err_set   = 1'b1;
            w_err_nxt   = BQLOAD_ERR_WB;
         end else if (wb.wb_rty_i) begin
            if (r_retry < 8'(MAX_RETRY)) begin
               w_retry_inc = 1'b1;
               w_state_nxt = ST_BACKOFF;
            end else begin
               w_state_nxt = ST_DONE;
               w_err_set   = 1'b1;
               w_err_nxt   = BQLOAD_ERR_RETRY;
            end
         end else if (wb.wb_ack_i) begin
`ifdef BQLOAD_READBACK_EN
            if (r_state == ST_WRITE) begin
               w_wr_ack    = 1'b1;
               w_state_nxt = ST_READ;
            end else if (wb.wb_dat_i != r_dat) begin
               w_state_nxt = ST_DONE;
               w_err_set   = 1'b1;
               w_err_nxt   = BQLOAD_ERR_MISMATCH;
            end else begin
               w_state_nxt = (r_words == r_count) ? ST_DONE : ST_FETCH;
            end
`else
            w_wr_ack    = 1'b1;
            w_state_nxt = w_last ? ST_DONE : ST_FETCH;
`endif
         end else if (w_tmo) begin
            w_state_nxt = ST_DONE;
            w_err_set   = 1'b1;
            w_err_nxt   = BQLOAD_ERR_TIMEOUT;
         end
      end else begin
         case (r_state)
            ST_IDLE:    if (start_i) w_state_nxt = ST_FETCH;
            // zero-length command passes through FETCH with ready low, so done lands two cycles after start
            ST_FETCH:   if (r_count == 8'd0) w_state_nxt = ST_DONE;
                        else if (w_hs)       w_state_nxt = ST_WRITE;
`ifdef BQLOAD_READBACK_EN
            ST_BACKOFF: w_state_nxt = r_rb ? ST_READ : ST_WRITE;
`else
            ST_BACKOFF: w_state_nxt = ST_WRITE;
`endif
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_base     <= '0;
         r_adr      <= '0;
         r_dat      <= '0;
         r_count    <= '0;
         r_words    <= '0;
         r_retry    <= '0;
         r_tmo      <= '0;
         r_cyc      <= 1'b0;
         r_we       <= 1'b0;
         r_sel      <= 4'h0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= BQLOAD_ERR_NONE;
      end else begin
         r_cyc   <= w_nxt_cyc;
         r_we    <= (w_state_nxt == ST_WRITE);
         r_sel   <= w_nxt_cyc ? 4'hF : 4'h0;
         r_ready <= (w_state_nxt == ST_FETCH) && (w_cnt_eff != 8'd0);
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= (w_state_nxt == ST_DONE);
         if ((r_state == ST_IDLE) && start_i) begin
            r_base     <= {base_adr_i[ADDR_WIDTH-1:2], 2'b00};
            r_count    <= count_i;
            r_words    <= '0;
            r_err      <= 1'b0;
            r_err_code <= BQLOAD_ERR_NONE;
         end
         if (w_hs) begin
            r_dat   <= coeff_dat_i;
            r_adr   <= r_base + w_off;
            r_retry <= '0;
         end
         if (w_retry_inc) r_retry <= r_retry + 8'd1;
         if (w_wr_ack)    r_words <= r_words + 8'd1;
         if (w_err_set) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_nxt;
         end
         if (w_nxt_cyc && (w_state_nxt != r_state)) r_tmo <= '0;
         else if (w_active)                         r_tmo <= r_tmo + 8'd1;
      end
   end

`ifdef BQLOAD_READBACK_EN
   // remembers which phase a retry backoff must return to
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)                      r_rb <= 1'b0;
      else if (w_state_nxt == ST_READ)   r_rb <= 1'b1;
      else if (w_hs)                     r_rb <= 1'b0;
   end
`endif

   assign wb.wb_cyc_o   = r_cyc;
   assign wb.wb_stb_o   = r_cyc;
   assign wb.wb_we_o    = r_we;
   assign wb.wb_adr_o   = r_adr;
   assign wb.wb_dat_o   = r_dat;
   assign wb.wb_sel_o   = r_sel;
   assign coeff_ready_o = r_ready;
   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign err_o         = r_err;
   assign err_code_o    = r_err_code;
   assign words_done_o  = r_words;

endmodule
